// File: rtl/pixel_scheduler_if.sv
// pixel_scheduler_if: groups the iteration-core request/result handshake and
// the framebuffer write port of the pixel scheduler.
// Signals:
//   core_start/core_ready   valid/ready pixel request to the core
//   c_re/c_im               Q4.12 pixel coordinate of the request
//   core_iter_limit         iteration limit for the request
//   core_done/core_iter     one-cycle result strobe and iteration count
//   fb_we/fb_addr/fb_data   framebuffer write port
// Modports: master = scheduler side, slave = core/framebuffer side.
interface pixel_scheduler_if #(
  parameter int COORD_WIDTH = 16,
  parameter int ITER_WIDTH  = 6,
  parameter int ADDR_WIDTH  = 12
);
  logic                   core_start;
  logic                   core_ready;
  logic [COORD_WIDTH-1:0] c_re;
  logic [COORD_WIDTH-1:0] c_im;
  logic [ITER_WIDTH-1:0]  core_iter_limit;
  logic                   core_done;
  logic [ITER_WIDTH-1:0]  core_iter;
  logic                   fb_we;
  logic [ADDR_WIDTH-1:0]  fb_addr;
  logic [ITER_WIDTH-1:0]  fb_data;

  modport master (
    output core_start, c_re, c_im, core_iter_limit, fb_we, fb_addr, fb_data,
    input  core_ready, core_done, core_iter
  );

  modport slave (
    input  core_start, c_re, c_im, core_iter_limit, fb_we, fb_addr, fb_data,
    output core_ready, core_done, core_iter
  );
endinterface

// File: rtl/pixel_scheduler.sv
// pixel_scheduler: walks one frame of GRID_W x GRID_H pixels through the
// Mandelbrot iteration core, one pixel at a time, and writes each (clamped)
// iteration count into the framebuffer in raster order.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   frame_start          frame pulse; accepted only in IDLE
//   centre_x, centre_y   signed Q4.12 view centre
//   zoom_level           pixel pitch = BASE_STEP >> zoom_level, minimum 1
//   max_iter_limit       iteration limit sent to the core, also clamps results
//   bus                  core handshake and framebuffer write (master side)
//   busy                 state is not IDLE
//   frame_done           one-cycle pulse after the last write
//   overrun              one-cycle pulse for a frame_start seen while busy
//
// state | meaning
// IDLE  | waiting for frame_start
// ISSUE | core_start high, coordinate held until core_ready
// WAIT  | request accepted, waiting for core_done
// WRITE | one-cycle framebuffer write, step to the next pixel
// DONE  | one-cycle frame_done pulse
module pixel_scheduler #(
  parameter int COORD_WIDTH = 16,
  parameter int ZOOM_WIDTH  = 8,
  parameter int ITER_WIDTH  = 6,
  parameter int GRID_W      = 64,
  parameter int GRID_H      = 48,
  parameter int ADDR_WIDTH  = 12,
  parameter int BASE_STEP   = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic signed [COORD_WIDTH-1:0] centre_x,
  input  logic signed [COORD_WIDTH-1:0] centre_y,
  input  logic [ZOOM_WIDTH-1:0]         zoom_level,
  input  logic [ITER_WIDTH-1:0]         max_iter_limit,
  pixel_scheduler_if.master             bus,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overrun
);
  localparam int COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam logic [COL_W-1:0]       LAST_COL = COL_W'(GRID_W - 1);
  localparam logic [ROW_W-1:0]       LAST_ROW = ROW_W'(GRID_H - 1);
  localparam logic [COORD_WIDTH-1:0] BASE     = COORD_WIDTH'(BASE_STEP);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;
  state_t state_q, state_d;

  // Multiply by a constant as a sum of shifted copies; wraps at COORD_WIDTH.
  function automatic logic [COORD_WIDTH-1:0] mul_const(
    input logic [COORD_WIDTH-1:0] v, input int k);
    logic [COORD_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < COORD_WIDTH; i++)
      if (k[i]) acc = acc + (v << i);
    return acc;
  endfunction

  logic [COORD_WIDTH-1:0] step_shift, step_new, x0_new, y0_new;
  // The centres and zoom are captured only through step_q/x0_q/c_im_q, which
  // is all the frame needs from them afterwards.
  logic [COORD_WIDTH-1:0] step_q, x0_q, c_re_q, c_im_q;
  logic [ITER_WIDTH-1:0]  limit_q, fb_data_q;
  logic [COL_W-1:0]       col_q;
  logic [ROW_W-1:0]       row_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   overrun_q;
  logic                   last_col, last_pixel;

  assign step_shift = BASE >> zoom_level;
  assign step_new   = (step_shift == '0) ? COORD_WIDTH'(1) : step_shift;
  assign x0_new     = centre_x - mul_const(step_new, GRID_W / 2);
  assign y0_new     = centre_y - mul_const(step_new, GRID_H / 2);

  assign last_col   = (col_q == LAST_COL);
  assign last_pixel = last_col && (row_q == LAST_ROW);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.core_start = 1'b0;
    bus.fb_we      = 1'b0;
    frame_done     = 1'b0;
    busy           = (state_q != IDLE);
    case (state_q)
      IDLE:  if (frame_start) state_d = ISSUE;
      ISSUE: begin
        bus.core_start = 1'b1;
        if (bus.core_ready) state_d = WAIT;
      end
      WAIT:  if (bus.core_done) state_d = WRITE;
      WRITE: begin
        bus.fb_we = 1'b1;
        state_d   = last_pixel ? DONE : ISSUE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q    <= '0;
      x0_q      <= '0;
      c_re_q    <= '0;
      c_im_q    <= '0;
      limit_q   <= '0;
      fb_data_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= frame_start && (state_q != IDLE);
      case (state_q)
        IDLE: if (frame_start) begin
          step_q  <= step_new;
          x0_q    <= x0_new;
          c_re_q  <= x0_new;
          c_im_q  <= y0_new;
          limit_q <= max_iter_limit;
          col_q   <= '0;
          row_q   <= '0;
          addr_q  <= '0;
        end
        WAIT: if (bus.core_done)
          fb_data_q <= (bus.core_iter > limit_q) ? limit_q : bus.core_iter;
        WRITE: if (!last_pixel) begin
          // Raster order makes the address a plain counter.
          addr_q <= addr_q + 1'b1;
          if (last_col) begin
            col_q  <= '0;
            row_q  <= row_q + 1'b1;
            c_re_q <= x0_q;
            c_im_q <= c_im_q + step_q;
          end else begin
            col_q  <= col_q + 1'b1;
            c_re_q <= c_re_q + step_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.c_re            = c_re_q;
  assign bus.c_im            = c_im_q;
  assign bus.core_iter_limit = limit_q;
  assign bus.fb_addr         = addr_q;
  assign bus.fb_data         = fb_data_q;
  assign overrun             = overrun_q;
endmodule

// File: tb/tb_pixel_scheduler.sv
module tb_pixel_scheduler;
  localparam int GRID_W = 64;
  localparam int GRID_H = 48;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame_start = 1'b0;
  logic signed [15:0] centre_x = '0;
  logic signed [15:0] centre_y = '0;
  logic [7:0]         zoom_level = '0;
  logic [5:0]         max_iter_limit = '0;
  logic               busy, frame_done, overrun;

  pixel_scheduler_if bus_if ();

  pixel_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start    (frame_start),
    .centre_x       (centre_x),
    .centre_y       (centre_y),
    .zoom_level     (zoom_level),
    .max_iter_limit (max_iter_limit),
    .bus            (bus_if),
    .busy           (busy),
    .frame_done     (frame_done),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference view of the current frame
  logic [15:0] step_m, x0_m, y0_m;
  logic [5:0]  lim_m;
  bit          iter_sat = 1'b0;
  int          req_n = 0, wr_cnt = 0, fd_cnt = 0, ov_cnt = 0;
  int          done_cnt = 0, stall_left = 0, bp_seen = 0;
  bit          bp_req = 1'b0, bp_hs = 1'b0, bp_wait = 1'b0;
  logic [5:0]  pend_iter = '0;
  logic [15:0] snap_re, snap_im;
  logic [15:0] req_re [3];
  logic [15:0] req_im [3];
  logic [17:0] exp_q [$];
  logic [17:0] exp_e;
  logic [15:0] er, ei;
  logic [5:0]  ed;
  int          col, row;

  // core model + scoreboard, acting on the falling edge
  initial begin
    bus_if.core_ready = 1'b1;
    bus_if.core_done  = 1'b0;
    bus_if.core_iter  = '0;
    forever begin
      @(negedge clk);
      bus_if.core_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          bus_if.core_done = 1'b1;
          bus_if.core_iter = pend_iter;
        end
      end
      if (frame_done) fd_cnt++;
      if (overrun) ov_cnt++;
      if (bus_if.fb_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check_val("fb_we_unexpected", 32'(bus_if.fb_we), 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check_val("fb_addr", 32'(bus_if.fb_addr), 32'(exp_e[17:6]));
          check_val("fb_data", 32'(bus_if.fb_data), 32'(exp_e[5:0]));
        end
      end
      if (bp_wait) begin
        bp_wait = 1'b0;
        check_val("bp_to_wait", 32'(bus_if.core_start), 32'd0);
      end
      if (bp_hs) begin
        bp_hs = 1'b0;
        bp_wait = 1'b1;
        check_val("bp_handshake", 32'(bus_if.core_start), 32'd1);
      end
      if (bp_req && bus_if.core_start) begin
        bp_req = 1'b0;
        bp_seen++;
        stall_left = 5;
        snap_re = bus_if.c_re;
        snap_im = bus_if.c_im;
      end
      if (stall_left > 0) begin
        bus_if.core_ready = 1'b0;
        stall_left--;
        check_val("bp_start", 32'(bus_if.core_start), 32'd1);
        check_val("bp_re", 32'(bus_if.c_re), 32'(snap_re));
        check_val("bp_im", 32'(bus_if.c_im), 32'(snap_im));
        check_val("bp_fb_we", 32'(bus_if.fb_we), 32'd0);
        if (stall_left == 0) bp_hs = 1'b1;
      end else begin
        bus_if.core_ready = 1'b1;
      end
      if (bus_if.core_start && bus_if.core_ready) begin
        col = req_n % GRID_W;
        row = req_n / GRID_W;
        er  = x0_m + 16'(col) * step_m;
        ei  = y0_m + 16'(row) * step_m;
        check_val("c_re", 32'(bus_if.c_re), 32'(er));
        check_val("c_im", 32'(bus_if.c_im), 32'(ei));
        check_val("iter_limit", 32'(bus_if.core_iter_limit), 32'(lim_m));
        if (req_n == 0)  begin req_re[0] = bus_if.c_re; req_im[0] = bus_if.c_im; end
        if (req_n == 1)  begin req_re[1] = bus_if.c_re; req_im[1] = bus_if.c_im; end
        if (req_n == 64) begin req_re[2] = bus_if.c_re; req_im[2] = bus_if.c_im; end
        pend_iter = iter_sat ? 6'd63 : 6'(col);
        ed = (pend_iter > lim_m) ? lim_m : pend_iter;
        exp_q.push_back({12'(req_n), ed});
        done_cnt = 2;
        req_n++;
      end
    end
  end

  task automatic start_frame(input logic [15:0] cx, input logic [15:0] cy,
                             input logic [7:0] zm, input logic [5:0] lim, input bit sat);
    int s;
    @(posedge clk); #2;
    centre_x = cx; centre_y = cy; zoom_level = zm; max_iter_limit = lim;
    frame_start = 1'b1;
    s = (zm > 8'd30) ? 0 : (128 >> zm);
    if (s < 1) s = 1;
    step_m = 16'(s);
    x0_m = cx - 16'(s * (GRID_W / 2));
    y0_m = cy - 16'(s * (GRID_H / 2));
    lim_m = lim; iter_sat = sat;
    req_n = 0; wr_cnt = 0; fd_cnt = 0; ov_cnt = 0;
    for (int i = 0; i < 3; i++) begin req_re[i] = '0; req_im[i] = '0; end
    @(posedge clk); #2;
    frame_start = 1'b0;
    // later parameter changes must not reach the running frame
    centre_x = 16'($urandom); centre_y = 16'($urandom);
    zoom_level = 8'($urandom_range(0, 12)); max_iter_limit = 6'($urandom);
  endtask

  task automatic wait_req(input int n, input string tag);
    int i = 0;
    while (req_n < n && i < 2000) begin @(posedge clk); i++; end
    #2;
    check_val(tag, 32'(req_n >= n), 32'd1);
  endtask

  task automatic wait_frame(input string tag);
    int i = 0;
    while (fd_cnt == 0 && i < 20000) begin @(posedge clk); i++; end
    #2;
    check_val(tag, 32'(fd_cnt), 32'd1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_core_start", 32'(bus_if.core_start), 32'd0);
    check_val("rst_fb_we", 32'(bus_if.fb_we), 32'd0);
    check_val("rst_c_re", 32'(bus_if.c_re), 32'd0);
    exp_q.delete();
    req_n = 0; stall_left = 0; bp_req = 1'b0;
    rst_n = 1'b1;
  endtask

  int saved_wr;

  initial begin
    // reset held with frame_start high
    rst_n = 1'b0; frame_start = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_core_start", 32'(bus_if.core_start), 32'd0);
    check_val("reset_fb_we", 32'(bus_if.fb_we), 32'd0);
    check_val("reset_outs", 32'({bus_if.c_re, bus_if.c_im}), 32'd0);
    check_val("reset_fb", 32'({bus_if.fb_addr, bus_if.fb_data, bus_if.core_iter_limit}), 32'd0);
    check_val("reset_pulses", 32'({frame_done, overrun}), 32'd0);
    frame_start = 1'b0; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // default view, full frame, with one backpressure episode
    start_frame(16'hF000, 16'h0000, 8'd0, 6'd63, 1'b0);
    wait_req(3, "wait_req3");
    check_val("busy_mid", 32'(busy), 32'd1);
    bp_req = 1'b1;
    wait_frame("frame_a_done");
    check_val("frame_a_writes", 32'(wr_cnt), 32'd3072);
    check_val("frame_a_sb_empty", 32'(exp_q.size()), 32'd0);
    check_val("req0_re", 32'(req_re[0]), 32'hE000);
    check_val("req0_im", 32'(req_im[0]), 32'hF400);
    check_val("req1_re", 32'(req_re[1]), 32'hE080);
    check_val("req64_re", 32'(req_re[2]), 32'hE000);
    check_val("req64_im", 32'(req_im[2]), 32'hF480);
    check_val("bp_seen", 32'(bp_seen), 32'd1);
    check_val("frame_a_overrun", 32'(ov_cnt), 32'd0);
    repeat (20) @(posedge clk);
    #2;
    check_val("frame_a_single_done", 32'(fd_cnt), 32'd1);
    check_val("frame_a_idle", 32'(busy), 32'd0);

    // zoom 3 and zoom 10 first requests
    start_frame(16'h0000, 16'h0000, 8'd3, 6'd63, 1'b0);
    wait_req(1, "wait_z3");
    check_val("z3_re", 32'(req_re[0]), 32'hFE00);
    check_val("z3_im", 32'(req_im[0]), 32'hFE80);
    apply_reset();
    start_frame(16'h0000, 16'h0000, 8'd10, 6'd63, 1'b0);
    wait_req(1, "wait_z10");
    check_val("z10_re", 32'(req_re[0]), 32'hFFE0);
    check_val("z10_im", 32'(req_im[0]), 32'hFFE8);
    apply_reset();

    // clamp to 31 and a frame_start at pixel 500
    start_frame(16'h0400, 16'hFC00, 8'd1, 6'd31, 1'b1);
    wait_req(500, "wait_req500");
    @(posedge clk); #2;
    centre_x = 16'h1234; zoom_level = 8'd5; max_iter_limit = 6'd7;
    frame_start = 1'b1;
    @(posedge clk); #2;
    frame_start = 1'b0;
    wait_frame("frame_c_done");
    check_val("frame_c_writes", 32'(wr_cnt), 32'd3072);
    check_val("frame_c_overrun", 32'(ov_cnt), 32'd1);
    check_val("frame_c_sb_empty", 32'(exp_q.size()), 32'd0);

    // reset mid-frame at address 100, then a fresh frame
    repeat (4) @(posedge clk);
    start_frame(16'h0800, 16'h0400, 8'd1, 6'd40, 1'b0);
    begin
      int i = 0;
      while (wr_cnt < 101 && i < 2000) begin @(posedge clk); i++; end
    end
    check_val("wait_addr100", 32'(wr_cnt >= 101), 32'd1);
    apply_reset();
    saved_wr = wr_cnt;
    repeat (12) @(posedge clk);
    #2;
    check_val("post_reset_writes", 32'(wr_cnt), 32'(saved_wr));
    check_val("post_reset_idle", 32'(busy), 32'd0);
    start_frame(16'h1000, 16'hF800, 8'd2, 6'd63, 1'b0);
    wait_req(1, "wait_after_reset");
    check_val("rf_re", 32'(req_re[0]), 32'h0C00);
    check_val("rf_im", 32'(req_im[0]), 32'hF500);
    begin
      int i = 0;
      while (wr_cnt < 3 && i < 200) begin @(posedge clk); i++; end
    end
    check_val("rf_writes", 32'(wr_cnt >= 3), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pixel_scheduler.md
Name: pixel_scheduler

Overview:
Sequences the Mandelbrot iteration core across one frame of a GRID_W x GRID_H pixel grid. On each frame start it latches the view parameters (centre, zoom, iteration limit) and derives the per-pixel complex coordinate incrementally, using shift and add only. It issues one pixel at a time to the core over a valid/ready handshake, waits for the core's result, and writes the iteration count into the framebuffer in raster order. It sits between the view-parameter controller and the iteration core / framebuffer write port.

Parameters:
COORD_WIDTH, 16, signed Q4.12 coordinate width
ZOOM_WIDTH, 8, zoom level width
ITER_WIDTH, 6, iteration count width
GRID_W, 64, pixels per row (even)
GRID_H, 48, rows per frame (even)
ADDR_WIDTH, 12, framebuffer address width (must satisfy 2^ADDR_WIDTH >= GRID_W*GRID_H)
BASE_STEP, 128, pixel pitch at zoom 0 in Q4.12 (0.03125)

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
frame_start  in  1  one-cycle pulse at vertical blank
centre_x  in  COORD_WIDTH  signed view centre, real part
centre_y  in  COORD_WIDTH  signed view centre, imaginary part
zoom_level  in  ZOOM_WIDTH  zoom level
max_iter_limit  in  ITER_WIDTH  iteration limit
core_start  out  1  valid: pixel request to the core
core_ready  in  1  core accepts the request
c_re  out  COORD_WIDTH  pixel real coordinate
c_im  out  COORD_WIDTH  pixel imaginary coordinate
core_iter_limit  out  ITER_WIDTH  latched iteration limit
core_done  in  1  one-cycle pulse: result valid
core_iter  in  ITER_WIDTH  result iteration count
fb_we  out  1  framebuffer write strobe
fb_addr  out  ADDR_WIDTH  row*GRID_W + col
fb_data  out  ITER_WIDTH  iteration count to store
busy  out  1  high whenever the state is not IDLE
frame_done  out  1  one-cycle pulse after the last write
overrun  out  1  one-cycle pulse when frame_start arrives while busy

Behaviour:
- Reset (rst_n low at a clk edge): state goes to IDLE; every output and internal register goes to 0. An in-flight core result is discarded; a core_done arriving after reset is ignored.
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE -> ISSUE on frame_start. On the same edge:
  - latch zoom, max_iter_limit and both centres;
  - step = BASE_STEP >> zoom_level, with a minimum of 1;
  - x0 = centre_x - step*(GRID_W/2);
  - y0 = centre_y - step*(GRID_H/2);
  - c_re = x0, c_im = y0, col = 0, row = 0.
  - Products are by constant and built from shift-adds. All coordinate arithmetic wraps modulo 2^COORD_WIDTH with no saturation.
- ISSUE: core_start = 1. c_re, c_im and core_iter_limit are held stable. A transfer happens when core_start and core_ready are both high at an edge; the state then moves to WAIT. If core_ready stays low, the state stays in ISSUE indefinitely.
- WAIT: core_start = 0. On core_done, fb_data <= min(core_iter, latched limit) and the state moves to WRITE. core_done in any other state is ignored.
- WRITE: fb_we = 1 for exactly one cycle, with fb_addr = row*GRID_W + col. On the same edge:
  - if col == GRID_W-1 and row == GRID_H-1: go to DONE;
  - else if col == GRID_W-1: col = 0, row += 1, c_re = x0, c_im += step, go to ISSUE;
  - else: col += 1, c_re += step, go to ISSUE.
- DONE: frame_done = 1 for one cycle, then IDLE.
- frame_start in any state other than IDLE: ignored, overrun pulses for one cycle, latched parameters are unchanged. frame_start in IDLE coinciding with rst_n low: reset wins.
- Input parameter changes mid-frame have no effect until the next accepted frame_start.
- Minimum per-pixel time: 3 cycles (ISSUE, WAIT, WRITE) plus the core latency.

Test Plan:
- Reset with frame_start held high -> busy=0, core_start=0, fb_we=0, all outputs 0.
- Default view: centre (-0x1000, 0), zoom 0, limit 63. Core model returns iter = col after 2 cycles.
  - First request: c_re=0xE000, c_im=0xF400.
  - Second request: c_re=0xE080.
  - Request 65: c_re=0xE000, c_im=0xF480.
  - 3072 writes at addresses 0..3071 in order, then exactly one frame_done.
- Backpressure: core_ready low for 5 cycles during ISSUE -> core_start, c_re and c_im unchanged, no fb_we; the handshake completes on the first ready cycle.
- Zoom: centre (0,0), zoom 3 -> step 16, first request c_re=0xFE00, c_im=0xFE80. Zoom 10 -> step 1, first request c_re=0xFFE0, c_im=0xFFE8.
- Clamp and overrun:
  - limit 31 with core_iter=63 -> fb_data=31.
  - frame_start at pixel 500 -> overrun pulses once, write sequence continues unchanged.
- Reset mid-frame at address 100 -> IDLE next cycle, no further fb_we. A late core_done is ignored. The next frame begins at fb_addr 0 with x0/y0 recomputed.
